// File: rtl/i2c_txn_arbiter.sv
// Two-port transaction arbiter in front of a shared multi-byte I2C master.
// Define I2C_ARB_RR_EN for round-robin tie breaking; the default is fixed priority with port 0 winning.
module i2c_txn_arbiter #(
  parameter int NREQ_BITS  = 1,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_start,
  input  logic       r1_start,
  input  logic       r0_data_valid,
  input  logic       r1_data_valid,
  input  logic       r0_stop,
  input  logic       r1_stop,
  input  logic [7:0] r0_data,
  input  logic [7:0] r1_data,
  output logic       r0_data_req,
  output logic       r1_data_req,
  output logic       r0_busy,
  output logic       r1_busy,
  output logic       r0_grant,
  output logic       r1_grant,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_data_valid,
  output logic [7:0] m_data_out,
  input  logic       m_data_req,
  input  logic       m_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  state_t               r_state;
  logic                 r_pend0;
  logic                 r_pend1;
  logic [NREQ_BITS-1:0] r_owner;
  logic                 r_grant0;
  logic                 r_grant1;
  logic                 r_m_start;
  logic                 r_gap_run;
  logic [7:0]           r_gap_cnt;
`ifdef I2C_ARB_RR_EN
  logic                 r_rr_ptr;
`endif

  logic w_req0;
  logic w_req1;
  logic w_pick1;
  logic w_own1;
  logic w_last;

  // A start seen in IDLE is arbitrated in the same cycle it lands in the pending latch.
  assign w_req0 = r_pend0 | r0_start;
  assign w_req1 = r_pend1 | r1_start;
  assign w_own1 = (r_owner != '0);

`ifdef I2C_ARB_RR_EN
  assign w_pick1 = w_req1 & (~w_req0 | r_rr_ptr);
`else
  assign w_pick1 = w_req1 & ~w_req0;
`endif

  assign w_last = (r_state == S_ACTIVE) &&
                  (w_own1 ? (r1_data_valid & r1_stop) : (r0_data_valid & r0_stop));

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
      r_owner   <= '0;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_m_start <= 1'b0;
      r_gap_run <= 1'b0;
      r_gap_cnt <= 8'd0;
`ifdef I2C_ARB_RR_EN
      r_rr_ptr  <= 1'b0;
`endif
    end else begin
      r_m_start <= 1'b0;
      if (r0_start && !r_grant0) r_pend0 <= 1'b1;
      if (r1_start && !r_grant1) r_pend1 <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if ((w_req0 || w_req1) && !m_busy) begin
            r_state   <= S_GRANT;
            r_owner   <= NREQ_BITS'(w_pick1);
            r_grant0  <= ~w_pick1;
            r_grant1  <= w_pick1;
            r_m_start <= 1'b1;
          end
        end

        S_GRANT: begin
          r_state <= S_ACTIVE;
          if (w_own1) r_pend1 <= 1'b0;
          else        r_pend0 <= 1'b0;
        end

        S_ACTIVE: begin
          if (w_last) begin
            r_state <= S_DRAIN;
`ifdef I2C_ARB_RR_EN
            r_rr_ptr <= ~w_own1;
`endif
          end
        end

        S_DRAIN: begin
          // Bus free time starts counting on the first cycle the master reports idle.
          if (r_gap_run) begin
            if (r_gap_cnt == 8'd1) begin
              r_state   <= S_IDLE;
              r_gap_run <= 1'b0;
              r_gap_cnt <= 8'd0;
              r_grant0  <= 1'b0;
              r_grant1  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt - 8'd1;
            end
          end else if (!m_busy) begin
            if (GAP_CYCLES == 0) begin
              r_state  <= S_IDLE;
              r_grant0 <= 1'b0;
              r_grant1 <= 1'b0;
            end else begin
              r_gap_run <= 1'b1;
              r_gap_cnt <= 8'(GAP_CYCLES);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_start  = r_m_start;
  assign r0_grant = r_grant0;
  assign r1_grant = r_grant1;
  assign r0_busy  = r_pend0 | r_grant0;
  assign r1_busy  = r_pend1 | r_grant1;

  // NOTE: every output gets a default before the case logic so no latch is inferred.
  always_comb begin
    m_data_valid = 1'b0;
    m_stop       = 1'b0;
    m_data_out   = 8'h00;
    r0_data_req  = 1'b0;
    r1_data_req  = 1'b0;
    if (r_state == S_ACTIVE) begin
      if (w_own1) begin
        m_data_valid = r1_data_valid;
        m_stop       = r1_stop;
        m_data_out   = r1_data;
        r1_data_req  = m_data_req;
      end else begin
        m_data_valid = r0_data_valid;
        m_stop       = r0_stop;
        m_data_out   = r0_data;
        r0_data_req  = m_data_req;
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (default build, GAP_CYCLES = 4).
module tb_i2c_txn_arbiter;

  logic       clk;
  logic       rst;
  logic       r0_start, r1_start;
  logic       r0_data_valid, r1_data_valid;
  logic       r0_stop, r1_stop;
  logic [7:0] r0_data, r1_data;
  logic       r0_data_req, r1_data_req;
  logic       r0_busy, r1_busy;
  logic       r0_grant, r1_grant;
  logic       m_start, m_stop, m_data_valid;
  logic [7:0] m_data_out;
  logic       m_data_req, m_busy;

  int n_checks = 0;
  int n_pass   = 0;

  i2c_txn_arbiter #(.NREQ_BITS(1), .GAP_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .r0_start      (r0_start),
    .r1_start      (r1_start),
    .r0_data_valid (r0_data_valid),
    .r1_data_valid (r1_data_valid),
    .r0_stop       (r0_stop),
    .r1_stop       (r1_stop),
    .r0_data       (r0_data),
    .r1_data       (r1_data),
    .r0_data_req   (r0_data_req),
    .r1_data_req   (r1_data_req),
    .r0_busy       (r0_busy),
    .r1_busy       (r1_busy),
    .r0_grant      (r0_grant),
    .r1_grant      (r1_grant),
    .m_start       (m_start),
    .m_stop        (m_stop),
    .m_data_valid  (m_data_valid),
    .m_data_out    (m_data_out),
    .m_data_req    (m_data_req),
    .m_busy        (m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs set here are sampled on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_start = 0; r1_start = 0;
    r0_data_valid = 0; r1_data_valid = 0;
    r0_stop = 0; r1_stop = 0;
    r0_data = 8'h00; r1_data = 8'h00;
    m_data_req = 0;
  endtask

  // Entered during the GRANT cycle G; one-byte transaction, master idles at G+3, IDLE seen at G+8.
  task automatic txn(input bit port, input logic [7:0] b);
    tick(); clear_inputs(); m_busy = 1; m_data_req = 1; #1;
    check("txn_req_owner", port ? r1_data_req : r0_data_req, 1);
    check("txn_req_other", port ? r0_data_req : r1_data_req, 0);
    tick(); clear_inputs();
    if (port) begin r1_data_valid = 1; r1_stop = 1; r1_data = b; end
    else      begin r0_data_valid = 1; r0_stop = 1; r0_data = b; end
    #1;
    check("txn_valid", m_data_valid, 1);
    check("txn_stop", m_stop, 1);
    check("txn_data", m_data_out, b);
    tick(); clear_inputs(); m_busy = 0; #1;
    check("txn_drain_valid", m_data_valid, 0);
    check("txn_drain_grant", port ? r1_grant : r0_grant, 1);
    repeat (4) tick();
    check("txn_gap_grant", port ? r1_grant : r0_grant, 1);
    tick();
    check("txn_idle_grant0", r0_grant, 0);
    check("txn_idle_grant1", r1_grant, 0);
  endtask

  initial begin
    logic [7:0] exp_byte;
    rst = 1; m_busy = 0;
    clear_inputs();

    // Reset state
    tick(); tick();
    check("rst_m_start", m_start, 0);
    check("rst_m_stop", m_stop, 0);
    check("rst_m_valid", m_data_valid, 0);
    check("rst_m_data", m_data_out, 8'h00);
    check("rst_grants", {r0_grant, r1_grant}, 2'b00);
    check("rst_busy", {r0_busy, r1_busy}, 2'b00);
    check("rst_data_req", {r0_data_req, r1_data_req}, 2'b00);
    rst = 0;

    // Port 0, 52-byte transaction; port 1 requests and misbehaves mid-way
    tick(); r0_start = 1; #1;
    check("t0_no_start_yet", m_start, 0);
    tick(); clear_inputs(); #1;
    check("t1_m_start", m_start, 1);
    check("t1_grant0", r0_grant, 1);
    check("t1_busy0", r0_busy, 1);
    check("t1_busy1", r1_busy, 0);
    tick(); m_busy = 1; #1;
    check("t2_start_gone", m_start, 0);
    check("t2_no_valid", m_data_valid, 0);

    for (int i = 0; i < 52; i++) begin
      exp_byte = (i == 51) ? 8'h00 : 8'(8'h10 + i);
      for (int k = 0; k < 9; k++) begin
        tick(); clear_inputs();
        if (i == 10 && k == 2) r1_start = 1;
        if (i == 21 && k == 4) begin r1_data_valid = 1; r1_stop = 1; r1_data = 8'hA5; end
        #1;
        if (i == 10 && k == 3) begin
          check("nonowner_busy1", r1_busy, 1);
          check("nonowner_grant1", r1_grant, 0);
        end
        if (i == 21 && k == 4) begin
          check("nonowner_strobe_valid", m_data_valid, 0);
          check("nonowner_strobe_stop", m_stop, 0);
        end
      end
      tick(); clear_inputs(); m_data_req = 1; #1;
      check("req_owner", r0_data_req, 1);
      check("req_nonowner", r1_data_req, 0);
      tick(); clear_inputs();
      r0_data_valid = 1; r0_data = exp_byte; r0_stop = (i == 51);
      if (i == 20) begin r1_data_valid = 1; r1_data = 8'hA5; end
      #1;
      check("byte_valid", m_data_valid, 1);
      check("byte_data", m_data_out, exp_byte);
      check("byte_stop", m_stop, (i == 51));
    end

    tick(); clear_inputs(); #1;
    check("drain_valid", m_data_valid, 0);
    check("drain_grant0", r0_grant, 1);
    tick(); tick();
    tick(); m_busy = 0; #1;
    repeat (4) tick();
    check("gap_grant0", r0_grant, 1);
    check("gap_busy1", r1_busy, 1);
    tick();
    check("idle_grant0", r0_grant, 0);
    check("idle_grant1", r1_grant, 0);
    check("idle_no_start", m_start, 0);
    tick();
    check("p1_grant", r1_grant, 1);
    check("p1_m_start", m_start, 1);
    txn(1'b1, 8'h5A);

    // Two simultaneous ties: expected order 0,1,0,1
    tick(); r0_start = 1; r1_start = 1; #1;
    tick(); clear_inputs(); #1;
    check("tie1_grant0", r0_grant, 1);
    check("tie1_grant1", r1_grant, 0);
    check("tie1_busy1", r1_busy, 1);
    txn(1'b0, 8'h11);
    tick();
    check("tie1_second_grant1", r1_grant, 1);
    check("tie1_second_start", m_start, 1);
    txn(1'b1, 8'h22);
    tick(); r0_start = 1; r1_start = 1; #1;
    tick(); clear_inputs(); #1;
    check("tie2_grant0", r0_grant, 1);
    check("tie2_grant1", r1_grant, 0);
    txn(1'b0, 8'h33);
    tick();
    check("tie2_second_grant1", r1_grant, 1);
    txn(1'b1, 8'h44);

    // Reset in the middle of an ACTIVE byte
    tick(); r0_start = 1; #1;
    tick(); clear_inputs(); #1;
    check("rstmid_start", m_start, 1);
    tick(); m_busy = 1; m_data_req = 1; r1_start = 1; #1;
    check("rstmid_req", r0_data_req, 1);
    tick(); clear_inputs(); r0_data_valid = 1; r0_data = 8'h3C; rst = 1; #1;
    check("rstmid_pend1", r1_busy, 1);
    check("rstmid_data", m_data_out, 8'h3C);
    tick(); rst = 0; clear_inputs(); m_busy = 0; m_data_req = 1; #1;
    check("rstmid_grants", {r0_grant, r1_grant}, 2'b00);
    check("rstmid_busy", {r0_busy, r1_busy}, 2'b00);
    check("rstmid_data_req", {r0_data_req, r1_data_req}, 2'b00);
    check("rstmid_m_start", m_start, 0);
    check("rstmid_m_valid", m_data_valid, 0);
    check("rstmid_m_stop", m_stop, 0);
    check("rstmid_m_data", m_data_out, 8'h00);
    tick(); clear_inputs(); r0_start = 1; #1;
    check("rstafter_no_start", m_start, 0);
    tick(); clear_inputs(); #1;
    check("rstafter_start", m_start, 1);
    check("rstafter_grant0", r0_grant, 1);
    txn(1'b0, 8'h99);

    // Foreign bus activity holds off the grant
    tick(); m_busy = 1; r0_start = 1; #1;
    tick(); clear_inputs(); #1;
    check("hold_busy0", r0_busy, 1);
    check("hold_grant0", r0_grant, 0);
    check("hold_start", m_start, 0);
    repeat (3) tick();
    check("hold_start_late", m_start, 0);
    tick(); m_busy = 0; #1;
    check("release_no_start", m_start, 0);
    tick();
    check("release_start", m_start, 1);
    check("release_grant0", r0_grant, 1);
    txn(1'b0, 8'h42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
